// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI3-style memory slave.
// Default widths, size/length encodings, response codes and FSM state enums.
package axi_pkg;

  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_ADD_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_SIZE_WIDTH = 3;
  localparam int DEF_BURST_W    = 2;
  localparam int DEF_MEM_BYTES  = 1024;

  localparam logic [2:0] AX_SIZE_1 = 3'd0;
  localparam logic [2:0] AX_SIZE_2 = 3'd1;
  localparam logic [2:0] AX_SIZE_4 = 3'd2;
  localparam logic [3:0] AX_LEN_1  = 4'd0;
  localparam logic [3:0] AX_LEN_2  = 4'd1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/mem_slave_ram.sv
// Byte-addressable RAM with a strobe-masked multi-byte write port and an
// asynchronous multi-byte read port; lanes beyond 1<<size are inactive.
module mem_slave_ram
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIZE_W     = DEF_SIZE_WIDTH,
  parameter int MEM_BYTES  = DEF_MEM_BYTES
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_BYTES)-1:0] waddr,
  input  logic [SIZE_W-1:0]            wsize,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic [$clog2(MEM_BYTES)-1:0] raddr,
  input  logic [SIZE_W-1:0]            rsize,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  // NOTE: the storage array has no reset; contents survive a bus reset and
  // clearing it would turn the array into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i] && ((i >> wsize) == 0)) mem[waddr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // NOTE: rdata gets a default before the loop so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >> rsize) == 0) rdata[8*i +: 8] = mem[raddr + AW'(i)];
    end
  end

endmodule

// File: rtl/mem_slave_top.sv
// AXI3-style memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// sharing one byte RAM, one outstanding transaction per direction, always OKAY.
module mem_slave_top
  import axi_pkg::*;
#(
  parameter int ADD_ID_WIDTH = DEF_ID_WIDTH,
  parameter int ADD_WIDTH    = DEF_ADD_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BURST_LEN    = DEF_LEN_WIDTH,
  parameter int BURST_SIZE   = DEF_SIZE_WIDTH,
  parameter int BURST_TYPE   = DEF_BURST_W,
  parameter int MEM_BYTES    = DEF_MEM_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADD_ID_WIDTH-1:0] arid,
  input  logic [ADD_WIDTH-1:0]    araddr,
  input  logic [BURST_LEN-1:0]    arlen,
  input  logic [BURST_SIZE-1:0]   arsize,
  input  logic [BURST_TYPE-1:0]   arburst,
  input  logic [1:0]              arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ADD_ID_WIDTH-1:0] rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADD_ID_WIDTH-1:0] awid,
  input  logic [ADD_WIDTH-1:0]    awaddr,
  input  logic [BURST_LEN-1:0]    awlen,
  input  logic [BURST_SIZE-1:0]   awsize,
  input  logic [BURST_TYPE-1:0]   awburst,
  input  logic [1:0]              awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADD_ID_WIDTH-1:0] wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ADD_ID_WIDTH-1:0] bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam logic [BURST_SIZE-1:0] MAX_SIZE = BURST_SIZE'($clog2(DATA_WIDTH / 8));

  function automatic logic [BURST_SIZE-1:0] clamp_size(input logic [BURST_SIZE-1:0] s);
    return (s > MAX_SIZE) ? MAX_SIZE : s;
  endfunction

  function automatic logic [MEM_AW-1:0] size_step(input logic [BURST_SIZE-1:0] s);
    return MEM_AW'(1) << s;
  endfunction

  w_state_e               w_state;
  logic [ADD_ID_WIDTH-1:0] w_id;
  logic [MEM_AW-1:0]       w_addr;
  logic [BURST_SIZE-1:0]   w_size;
  logic [BURST_LEN-1:0]    w_len, w_beat;

  r_state_e               r_state;
  logic [MEM_AW-1:0]       r_addr;
  logic [BURST_SIZE-1:0]   r_size;
  logic [BURST_LEN-1:0]    r_len, r_beat;

  logic                    ram_we;
  logic [MEM_AW-1:0]       rd_addr;
  logic [BURST_SIZE-1:0]   rd_size;
  logic [DATA_WIDTH-1:0]   rd_data;

  // A beat sampled while reset is asserted is part of an abandoned burst.
  assign ram_we = wvalid && wready && reset;

  // The read port looks at the incoming AR while idle, else at the next beat.
  always_comb begin
    rd_addr = r_addr + size_step(r_size);
    rd_size = r_size;
    if (r_state == R_IDLE) begin
      rd_addr = araddr[MEM_AW-1:0];
      rd_size = clamp_size(arsize);
    end
  end

  mem_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE_W     (BURST_SIZE),
    .MEM_BYTES  (MEM_BYTES)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_addr),
    .wsize (w_size),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (rd_addr),
    .rsize (rd_size),
    .rdata (rd_data)
  );

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_size  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr[MEM_AW-1:0];
            w_size  <= clamp_size(awsize);
            w_len   <= awlen;
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            w_addr <= w_addr + size_step(w_size);
            w_beat <= w_beat + 1'b1;
            if (w_beat == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr[MEM_AW-1:0];
            r_size  <= clamp_size(arsize);
            r_len   <= arlen;
            r_beat  <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rresp   <= RESP_OKAY;
            rlast   <= (arlen == '0);
            rdata   <= rd_data;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_beat == r_len) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= rd_addr;
              r_beat <= r_beat + 1'b1;
              rlast  <= (BURST_LEN'(r_beat + 1'b1) == r_len);
              rdata  <= rd_data;
            end
          end
        end
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{awaddr[ADD_WIDTH-1:MEM_AW], araddr[ADD_WIDTH-1:MEM_AW],
                           awburst, arburst, awlock, arlock, awcache, arcache,
                           awprot, arprot, wid, wlast};

endmodule

// File: tb/tb_mem_slave_top.sv
// Self-checking bench for mem_slave_top: randomized AXI traffic compared
// against a byte-array model of the slave's memory.
module tb_mem_slave_top;
  import axi_pkg::*;

  localparam int IDW  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NB   = DW / 8;
  localparam int MEMB = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [IDW-1:0] arid, awid, wid, rid, bid;
  logic [AW-1:0]  araddr, awaddr;
  logic [3:0]     arlen, awlen, arcache, awcache;
  logic [2:0]     arsize, awsize, arprot, awprot;
  logic [1:0]     arburst, awburst, arlock, awlock, rresp, bresp;
  logic           arvalid, arready, rlast, rvalid, rready;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]  rdata, wdata;
  logic [NB-1:0]  wstrb;

  mem_slave_top #(
    .ADD_ID_WIDTH(IDW), .ADD_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(4),
    .BURST_SIZE(3), .BURST_TYPE(2), .MEM_BYTES(MEMB)
  ) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  logic [7:0]    ref_mem [MEMB];
  logic [DW-1:0] wdata_q [16];
  logic [NB-1:0] wstrb_q [16];
  int n_vec = 0;
  int n_err = 0;

  function automatic int beat_bytes(input logic [2:0] size);
    return (size > 3'd2) ? NB : (1 << size);
  endfunction

  task automatic axi_write(input logic [IDW-1:0] id, input int addr, input int len,
                           input logic [2:0] size, input int b_hold, input int gap);
    int a, nb, n;
    awid = id; awaddr = AW'(addr); awlen = 4'(len); awsize = size;
    awburst = 2'($urandom); awlock = 2'($urandom); awcache = 4'($urandom);
    awprot = 3'($urandom); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    n_vec++;
    if (awready !== 1'b1) begin
      n_err++; $display("FAIL aw_handshake: awready=%b expected 1", awready);
      awvalid = 1'b0; return;
    end
    @(negedge clk); awvalid = 1'b0;
    a = addr; nb = beat_bytes(size);
    for (int b = 0; b <= len; b++) begin
      if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
      wid = IDW'($urandom); wdata = wdata_q[b]; wstrb = wstrb_q[b];
      wlast = (b == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      n_vec++;
      if (wready !== 1'b1) begin
        n_err++; $display("FAIL w_handshake beat %0d: wready=%b expected 1", b, wready);
        wvalid = 1'b0; return;
      end
      @(negedge clk); wvalid = 1'b0;
      for (int i = 0; i < nb; i++)
        if (wstrb_q[b][i]) ref_mem[(a + i) % MEMB] = wdata_q[b][8*i +: 8];
      a += nb;
    end
    bready = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    n_vec++;
    if (bvalid !== 1'b1) begin
      n_err++; $display("FAIL b_wait: bvalid=%b expected 1", bvalid); return;
    end
    n_vec++;
    if (bid !== id || bresp !== RESP_OKAY) begin
      n_err++; $display("FAIL b_fields: bid=%h bresp=%b expected bid=%h bresp=00", bid, bresp, id);
    end
    repeat (b_hold) begin
      @(negedge clk);
      n_vec++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_err++; $display("FAIL b_hold: bvalid=%b awready=%b expected 1/0", bvalid, awready);
      end
    end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL b_once: bvalid=%b after handshake expected 0", bvalid);
    end
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input int addr, input int len,
                          input logic [2:0] size, input int stall, input bit rand_stall);
    logic [DW-1:0] exp [16];
    logic [DW-1:0] e, hold_d;
    logic [IDW-1:0] hold_id;
    logic hold_last;
    int a, nb, n, k;
    a = addr; nb = beat_bytes(size);
    for (int b = 0; b <= len; b++) begin
      e = '0;
      for (int i = 0; i < nb; i++) e[8*i +: 8] = ref_mem[(a + i) % MEMB];
      exp[b] = e; a += nb;
    end
    arid = id; araddr = AW'(addr); arlen = 4'(len); arsize = size;
    arburst = 2'($urandom); arlock = 2'($urandom); arcache = 4'($urandom);
    arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    n_vec++;
    if (arready !== 1'b1) begin
      n_err++; $display("FAIL ar_handshake: arready=%b expected 1", arready);
      arvalid = 1'b0; return;
    end
    @(negedge clk); arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      n_vec++;
      if (rvalid !== 1'b1) begin
        n_err++; $display("FAIL r_wait beat %0d: rvalid=%b expected 1", b, rvalid); return;
      end
      k = rand_stall ? $urandom_range(stall, 0) : stall;
      hold_d = rdata; hold_id = rid; hold_last = rlast;
      repeat (k) begin
        @(negedge clk);
        n_vec++;
        if (rvalid !== 1'b1 || rdata !== hold_d || rid !== hold_id || rlast !== hold_last) begin
          n_err++;
          $display("FAIL r_stall beat %0d: rvalid=%b rdata=%h rid=%h rlast=%b expected 1 %h %h %b",
                   b, rvalid, rdata, rid, rlast, hold_d, hold_id, hold_last);
        end
      end
      rready = 1'b1;
      n_vec++;
      if (rdata !== exp[b] || rid !== id || rresp !== RESP_OKAY || rlast !== (b == len)) begin
        n_err++;
        $display("FAIL r_beat %0d @%h: rdata=%h rid=%h rresp=%b rlast=%b expected %h %h 00 %b",
                 b, addr, rdata, rid, rresp, rlast, exp[b], id, (b == len));
      end
      @(negedge clk); rready = 1'b0;
    end
    n_vec++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_err++; $display("FAIL r_done: rvalid=%b arready=%b expected 0/1", rvalid, arready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 ||
        rdata !== '0 || rid !== '0 || bid !== '0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: aw/w/b/ar/r/last=%b rdata=%h rid=%h bid=%h expected all 0",
               {awready, wready, bvalid, arready, rvalid, rlast}, rdata, rid, bid);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      n_err++; $display("FAIL reset_release: awready=%b arready=%b expected 1/1", awready, arready);
    end
  endtask

  task automatic test_clear();
    for (int b = 0; b < 16; b++) begin wdata_q[b] = '0; wstrb_q[b] = '1; end
    for (int k = 0; k < MEMB / 64; k++) axi_write(IDW'(k), k * 64, 15, AX_SIZE_4, 0, 0);
  endtask

  task automatic test_sequential();
    wdata_q[0] = 32'h00; wstrb_q[0] = '1;
    axi_write(4'd0, 0, 0, AX_SIZE_1, 0, 0);
    wdata_q[0] = 32'h0201;
    axi_write(4'd0, 1, 0, AX_SIZE_2, 0, 0);
    wdata_q[0] = 32'h0403; wdata_q[1] = 32'h0605; wstrb_q[1] = '1;
    axi_write(4'd0, 3, 1, AX_SIZE_2, 0, 0);
    axi_read(4'd0, 0, 0, AX_SIZE_1, 0, 0);
    axi_read(4'd0, 1, 0, AX_SIZE_2, 0, 0);
    axi_read(4'd0, 3, 1, AX_SIZE_2, 0, 0);
  endtask

  task automatic test_strobe();
    wdata_q[0] = 32'hAABBCCDD; wstrb_q[0] = 4'b0101;
    axi_write(4'd1, 32'h10, 0, AX_SIZE_4, 0, 0);
    axi_read(4'd1, 32'h10, 0, AX_SIZE_4, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 4; b++) begin wdata_q[b] = $urandom; wstrb_q[b] = '1; end
    axi_write(4'd6, 32'h100, 3, AX_SIZE_4, 5, 0);
    axi_read(4'd9, 32'h100, 3, AX_SIZE_4, 3, 0);
  endtask

  task automatic test_wrap();
    wdata_q[0] = 32'h2211; wstrb_q[0] = '1;
    axi_write(4'd2, MEMB - 1, 0, AX_SIZE_2, 0, 0);
    axi_read(4'd2, MEMB - 1, 0, AX_SIZE_1, 0, 0);
    axi_read(4'd2, 0, 0, AX_SIZE_1, 0, 0);
    axi_read(4'd2, MEMB - 1, 0, AX_SIZE_2, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    int n;
    awid = 4'd2; awaddr = 32'h80; awlen = 4'd3; awsize = AX_SIZE_4; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'h11223344; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    n_vec++;
    if (wready !== 1'b1) begin
      n_err++; $display("FAIL rst_first_beat: wready=%b expected 1", wready);
    end
    @(negedge clk); wvalid = 1'b0;
    for (int i = 0; i < NB; i++) ref_mem[32'h80 + i] = wdata[8*i +: 8];
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_mid: aw/w/b/ar/r=%b expected 00000", {awready, wready, bvalid, arready, rvalid});
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (awready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: awready=%b arready=%b bvalid=%b expected 1 1 0", awready, arready, bvalid);
    end
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if (bvalid !== 1'b0) begin n_err++; $display("FAIL rst_no_b: bvalid=%b expected 0", bvalid); end
    end
    for (int b = 0; b < 2; b++) begin wdata_q[b] = $urandom; wstrb_q[b] = '1; end
    axi_write(4'd7, 32'h84, 1, AX_SIZE_4, 0, 0);
    axi_read(4'd7, 32'h80, 3, AX_SIZE_4, 0, 0);
  endtask

  task automatic test_concurrent();
    wdata_q[0] = 32'hCAFEF00D; wstrb_q[0] = '1;
    axi_write(4'd1, 32'h40, 0, AX_SIZE_4, 0, 0);
    wdata_q[0] = 32'h5A5A1234;
    fork
      axi_write(4'd5, 32'h40, 0, AX_SIZE_4, 0, 0);
      axi_read(4'd3, 32'h40, 0, AX_SIZE_4, 0, 0);
    join
    axi_read(4'd3, 32'h40, 0, AX_SIZE_4, 0, 0);
  endtask

  task automatic test_random();
    int addr, len;
    for (int t = 0; t < 30; t++) begin
      addr = $urandom_range(MEMB - 1, 0);
      len  = $urandom_range(7, 0);
      for (int b = 0; b <= len; b++) begin wdata_q[b] = $urandom; wstrb_q[b] = NB'($urandom); end
      axi_write(IDW'($urandom), addr, len, 3'($urandom_range(3, 0)), $urandom_range(2, 0), 2);
      axi_read(IDW'($urandom), addr, $urandom_range(7, 0), 3'($urandom_range(3, 0)), 2, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
    @(negedge clk);
    test_reset();
    test_clear();
    test_sequential();
    test_strobe();
    test_backpressure();
    test_wrap();
    test_reset_mid_write();
    test_concurrent();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
